// File: rtl/clint_ctrl_if.sv
`default_nettype none
// =====================================================================
// clint_ctrl_if : CSR-file port bundle between clint_ctrl and the CSR
//                 register file (write port out, current CSR values in).
// Revision      : 1.0
// =====================================================================
interface clint_ctrl_if;
  logic        csr_we_o;
  logic [31:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_raddr_o;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic [31:0] csr_mstatus_i;
  logic        global_int_en_i;

  modport master (
    output csr_we_o, csr_waddr_o, csr_wdata_o, csr_raddr_o,
    input  csr_mtvec_i, csr_mepc_i, csr_mstatus_i, global_int_en_i
  );

  modport slave (
    input  csr_we_o, csr_waddr_o, csr_wdata_o, csr_raddr_o,
    output csr_mtvec_i, csr_mepc_i, csr_mstatus_i, global_int_en_i
  );
endinterface
`default_nettype wire

// File: rtl/clint_ctrl.sv
`default_nettype none
// =====================================================================
// clint_ctrl : trap/MRET sequencer; writes mepc, mcause, (mtval), mstatus
//              one per cycle, then redirects the PC. Option: CLINT_MTVAL_EN
// Revision   : 1.0
// =====================================================================
module clint_ctrl #(
  parameter int INT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [INT_W-1:0] int_flag_i,
  input  wire logic [31:0]      inst_i,
  input  wire logic [31:0]      inst_addr_i,
  input  wire logic             ex_jump_flag_i,
  input  wire logic [31:0]      ex_jump_addr_i,
  clint_ctrl_if.master          csr_if,
  output logic                  hold_flag_o,
  output logic                  int_assert_o,
  output logic [31:0]           int_addr_o
);

  localparam logic [31:0] C_INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] C_INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] C_INST_MRET   = 32'h3020_0073;
  localparam logic [11:0] C_CSR_MEPC    = 12'h341;
  localparam logic [11:0] C_CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] C_CSR_MTVAL   = 12'h343;
  localparam logic [11:0] C_CSR_MSTATUS = 12'h300;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_MEPC        = 3'd1,
    S_MCAUSE      = 3'd2,
`ifdef CLINT_MTVAL_EN
    S_MTVAL       = 3'd3,
`endif
    S_MSTATUS     = 3'd4,
    S_ASSERT      = 3'd5,
    S_MRET        = 3'd6,
    S_MRET_ASSERT = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
`ifdef CLINT_MTVAL_EN
  logic [31:0] tval_q, tval_d;
`endif
  logic        csr_we_q, csr_we_d;
  logic [11:0] csr_waddr_q, csr_waddr_d;
  logic        int_assert_q, int_assert_d;
  logic [31:0] int_addr_q, int_addr_d;

  logic        w_ecall, w_ebreak, w_mret, w_irq;
  logic [31:0] w_wdata;
  logic [31:0] w_mst;

  assign w_ecall  = (inst_i == C_INST_ECALL);
  assign w_ebreak = (inst_i == C_INST_EBREAK);
  assign w_mret   = (inst_i == C_INST_MRET);
  assign w_irq    = csr_if.global_int_en_i && (|int_flag_i);
  assign w_mst    = csr_if.csr_mstatus_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cause_d      = cause_q;
`ifdef CLINT_MTVAL_EN
    tval_d       = tval_q;
`endif
    csr_we_d     = 1'b0;
    csr_waddr_d  = 12'h000;
    int_assert_d = 1'b0;
    int_addr_d   = 32'h0;
    case (state_q)
      S_IDLE: begin
        // Sync events outrank the interrupt, which simply stays pending.
        if (w_ecall || w_ebreak) begin
          state_d     = S_MEPC;
          pc_d        = inst_addr_i;
          cause_d     = w_ecall ? 32'd11 : 32'd3;
`ifdef CLINT_MTVAL_EN
          tval_d      = inst_i;
`endif
          csr_we_d    = 1'b1;
          csr_waddr_d = C_CSR_MEPC;
        end else if (w_mret) begin
          state_d     = S_MRET;
          csr_we_d    = 1'b1;
          csr_waddr_d = C_CSR_MSTATUS;
        end else if (w_irq) begin
          state_d     = S_MEPC;
          pc_d        = ex_jump_flag_i ? ex_jump_addr_i : inst_addr_i;
          cause_d     = int_flag_i[0] ? 32'h8000_0007 : 32'h8000_000B;
`ifdef CLINT_MTVAL_EN
          tval_d      = 32'h0;
`endif
          csr_we_d    = 1'b1;
          csr_waddr_d = C_CSR_MEPC;
        end
      end
      S_MEPC: begin
        state_d     = S_MCAUSE;
        csr_we_d    = 1'b1;
        csr_waddr_d = C_CSR_MCAUSE;
      end
      S_MCAUSE: begin
`ifdef CLINT_MTVAL_EN
        state_d     = S_MTVAL;
        csr_waddr_d = C_CSR_MTVAL;
`else
        state_d     = S_MSTATUS;
        csr_waddr_d = C_CSR_MSTATUS;
`endif
        csr_we_d    = 1'b1;
      end
`ifdef CLINT_MTVAL_EN
      S_MTVAL: begin
        state_d     = S_MSTATUS;
        csr_we_d    = 1'b1;
        csr_waddr_d = C_CSR_MSTATUS;
      end
`endif
      S_MSTATUS: begin
        state_d      = S_ASSERT;
        int_assert_d = 1'b1;
        int_addr_d   = csr_if.csr_mtvec_i;
      end
      S_MRET: begin
        state_d      = S_MRET_ASSERT;
        int_assert_d = 1'b1;
        int_addr_d   = csr_if.csr_mepc_i;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // mstatus data is formed from the live CSR value inside the write state itself.
  always_comb begin
    w_wdata = 32'h0;
    case (state_q)
      S_MEPC:    w_wdata = pc_q;
      S_MCAUSE:  w_wdata = cause_q;
`ifdef CLINT_MTVAL_EN
      S_MTVAL:   w_wdata = tval_q;
`endif
      S_MSTATUS: w_wdata = {w_mst[31:8], w_mst[3], w_mst[6:4], 1'b0, w_mst[2:0]};
      S_MRET:    w_wdata = {w_mst[31:8], 1'b1, w_mst[6:4], w_mst[7], w_mst[2:0]};
      default:   w_wdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= 32'h0;
      cause_q      <= 32'h0;
`ifdef CLINT_MTVAL_EN
      tval_q       <= 32'h0;
`endif
      csr_we_q     <= 1'b0;
      csr_waddr_q  <= 12'h000;
      int_assert_q <= 1'b0;
      int_addr_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cause_q      <= cause_d;
`ifdef CLINT_MTVAL_EN
      tval_q       <= tval_d;
`endif
      csr_we_q     <= csr_we_d;
      csr_waddr_q  <= csr_waddr_d;
      int_assert_q <= int_assert_d;
      int_addr_q   <= int_addr_d;
    end
  end

  assign hold_flag_o        = (state_q != S_IDLE) || w_ecall || w_ebreak || w_mret || w_irq;
  assign int_assert_o       = int_assert_q;
  assign int_addr_o         = int_addr_q;
  assign csr_if.csr_we_o    = csr_we_q;
  assign csr_if.csr_waddr_o = {20'h0, csr_waddr_q};
  assign csr_if.csr_wdata_o = w_wdata;
  assign csr_if.csr_raddr_o = 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_clint_ctrl.sv
`default_nettype none
// =====================================================================
// tb_clint_ctrl : directed + random bench for clint_ctrl with a small
//                 CSR-file model (mstatus/mepc/mtvec) driving its inputs.
// Revision      : 1.0
// =====================================================================
module tb_clint_ctrl;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  tb_flags = 8'h0;
  logic [31:0] tb_inst = 32'h13;
  logic [31:0] tb_pc = 32'h0;
  logic        tb_exf = 1'b0;
  logic [31:0] tb_exa = 32'h0;
  logic        hold_flag, int_assert;
  logic [31:0] int_addr;

  logic [31:0] m_mstatus = 32'h0;
  logic [31:0] m_mepc = 32'h0;
  logic [31:0] m_mtvec = 32'h0;

  int errors = 0;
  int checks = 0;

  clint_ctrl_if csr_if();
  assign csr_if.csr_mtvec_i     = m_mtvec;
  assign csr_if.csr_mepc_i      = m_mepc;
  assign csr_if.csr_mstatus_i   = m_mstatus;
  assign csr_if.global_int_en_i = m_mstatus[3];

  clint_ctrl #(.INT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .int_flag_i     (tb_flags),
    .inst_i         (tb_inst),
    .inst_addr_i    (tb_pc),
    .ex_jump_flag_i (tb_exf),
    .ex_jump_addr_i (tb_exa),
    .csr_if         (csr_if),
    .hold_flag_o    (hold_flag),
    .int_assert_o   (int_assert),
    .int_addr_o     (int_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    return (m & ~32'h88) | (m[3] ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    return (m & ~32'h08) | (m[7] ? 32'h08 : 32'h0) | 32'h80;
  endfunction

  task automatic check_quiet(input string tag, input logic exp_hold);
    check({tag, "_we"}, 32'(csr_if.csr_we_o), 32'h0);
    check({tag, "_waddr"}, csr_if.csr_waddr_o, 32'h0);
    check({tag, "_wdata"}, csr_if.csr_wdata_o, 32'h0);
    check({tag, "_assert"}, 32'(int_assert), 32'h0);
    check({tag, "_hold"}, 32'(hold_flag), 32'(exp_hold));
  endtask

  // Called just after a falling edge; presents one decode-stage event and
  // checks the full cycle-by-cycle reaction against the model.
  task automatic do_event(input logic [31:0] inst, input logic [31:0] pc,
                          input logic [7:0] flags, input logic exf, input logic [31:0] exa);
    logic [11:0] wa[$];
    logic [31:0] wd[$];
    logic        is_trap, is_mret;
    logic [31:0] ret_pc, cause, tval, tgt;
    is_trap = 1'b0; is_mret = 1'b0;
    ret_pc = 32'h0; cause = 32'h0; tval = 32'h0; tgt = 32'h0;
    if (inst == ECALL || inst == EBREAK) begin
      is_trap = 1'b1; ret_pc = pc; tval = inst;
      cause = (inst == ECALL) ? 32'd11 : 32'd3;
    end else if (inst == MRET) begin
      is_mret = 1'b1;
    end else if (m_mstatus[3] && flags != 8'h0) begin
      is_trap = 1'b1; ret_pc = exf ? exa : pc; tval = 32'h0;
      cause = flags[0] ? 32'h8000_0007 : 32'h8000_000B;
    end
    tb_inst = inst; tb_pc = pc; tb_flags = flags; tb_exf = exf; tb_exa = exa;
    #1;
    check("hold_detect", 32'(hold_flag), 32'(is_trap | is_mret));
    if (!(is_trap | is_mret)) begin
      repeat (3) begin
        @(posedge clk); @(negedge clk);
        check_quiet("no_event", 1'b0);
      end
      tb_flags = 8'h0; tb_inst = NOP;
      return;
    end
    if (is_trap) begin
      wa.push_back(12'h341); wd.push_back(ret_pc);
      wa.push_back(12'h342); wd.push_back(cause);
`ifdef CLINT_MTVAL_EN
      wa.push_back(12'h343); wd.push_back(tval);
`endif
      wa.push_back(12'h300); wd.push_back(trap_mstatus(m_mstatus));
      tgt = m_mtvec;
    end else begin
      wa.push_back(12'h300); wd.push_back(mret_mstatus(m_mstatus));
      tgt = m_mepc;
    end
    for (int i = 0; i < wa.size(); i++) begin
      @(posedge clk); @(negedge clk);
      check("wr_we", 32'(csr_if.csr_we_o), 32'h1);
      check("wr_waddr", csr_if.csr_waddr_o, {20'h0, wa[i]});
      check("wr_wdata", csr_if.csr_wdata_o, wd[i]);
      check("wr_assert", 32'(int_assert), 32'h0);
      check("wr_hold", 32'(hold_flag), 32'h1);
      if (wa[i] == 12'h341) m_mepc = wd[i];
      if (wa[i] == 12'h300) m_mstatus = wd[i];
      // Decode moves on; captured values must not follow it.
      tb_inst = NOP; tb_pc = $urandom; tb_exf = 1'b0; tb_exa = $urandom;
    end
    @(posedge clk); @(negedge clk);
    check("asr_assert", 32'(int_assert), 32'h1);
    check("asr_addr", int_addr, tgt);
    check("asr_we", 32'(csr_if.csr_we_o), 32'h0);
    check("asr_wdata", csr_if.csr_wdata_o, 32'h0);
    check("asr_hold", 32'(hold_flag), 32'h1);
    @(posedge clk); @(negedge clk);
    check_quiet("post_idle", m_mstatus[3] && (tb_flags != 8'h0));
    tb_flags = 8'h0;
  endtask

  initial begin
    int k;
    logic [7:0]  fl;
    logic [31:0] ins;
    rst = 1'b0;
    m_mtvec = 32'h200; m_mstatus = 32'h8; m_mepc = 32'h0;
    @(negedge clk);
    check_quiet("reset", 1'b0);
    check("reset_addr", int_addr, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // ECALL at 0x100, mtvec 0x200, mstatus 0x8
    do_event(ECALL, 32'h100, 8'h00, 1'b0, 32'h0);
    check("ecall_mstatus_model", m_mstatus, 32'h80);
    // Timer interrupt taken from an execute redirect
    m_mstatus = 32'h8;
    do_event(NOP, 32'h120, 8'h01, 1'b1, 32'h400);
    // External interrupt cause
    m_mstatus = 32'h8;
    do_event(NOP, 32'h124, 8'h04, 1'b0, 32'h0);
    // Masked interrupt: nothing happens
    m_mstatus = 32'h0;
    do_event(NOP, 32'h128, 8'h02, 1'b0, 32'h0);
    // MRET with mstatus 0x80, mepc 0x104
    m_mstatus = 32'h80; m_mepc = 32'h104;
    do_event(MRET, 32'h130, 8'h00, 1'b0, 32'h0);
    // EBREAK and timer interrupt together: cause 3, no retake
    m_mstatus = 32'h8;
    do_event(EBREAK, 32'h140, 8'h01, 1'b0, 32'h0);

    // Reset during MCAUSE aborts the sequence
    m_mstatus = 32'h8; m_mtvec = 32'h200;
    tb_inst = ECALL; tb_pc = 32'h150;
    @(posedge clk); @(negedge clk);
    check("rst_seq_mepc", csr_if.csr_waddr_o, 32'h341);
    m_mepc = 32'h150; tb_inst = NOP;
    @(posedge clk); @(negedge clk);
    check("rst_seq_mcause", csr_if.csr_waddr_o, 32'h342);
    rst = 1'b0;
    #1;
    check_quiet("rst_abort", 1'b0);
    check("rst_abort_addr", int_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      check_quiet("rst_after", 1'b0);
    end

    // Random events against the model
    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(0, 5));
      m_mstatus = $urandom;
      m_mtvec = $urandom & 32'hFFFF_FFFC;
      m_mepc = $urandom & 32'hFFFF_FFFC;
      fl = 8'($urandom);
      ins = NOP;
      case (k)
        0: ins = ECALL;
        1: ins = EBREAK;
        2: begin ins = MRET; fl = 8'h0; end
        3: begin m_mstatus[3] = 1'b1; fl = 8'($urandom_range(1, 255)); end
        4: begin m_mstatus[3] = 1'b0; fl = 8'($urandom_range(1, 255)); end
        default: begin
          ins = ($urandom_range(0, 1) == 0) ? ECALL : EBREAK;
          m_mstatus[3] = 1'b1; fl = 8'($urandom_range(1, 255));
        end
      endcase
      do_event(ins, $urandom & 32'hFFFF_FFFC, fl, 1'($urandom), $urandom & 32'hFFFF_FFFC);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
